regfile_wb_arbiter: RTL and testbench

Write-port arbiter and hazard tracker for the 32 x 32 register file. Two writeback sources (requester 0: ALU/execute result, requester 1: load/memory result) compete for the register file's single write port (WE3/A3/WD3). The block grants one request per cycle with round-robin fairness, registers the winning write onto the port, suppresses writes to x0, and reports per-address pending-write status to the decode stage for stall decisions.

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-port arbiter and hazard tracker for the 32 x 32 register file.
// Two writeback sources share the single write port (WE3/A3/WD3):
//   requester 0 = ALU/execute result, requester 1 = load/memory result.
// One request is granted per cycle with round-robin fairness. The winning
// write is registered onto the port. Writes to x0 are accepted but dropped.
// Per-address pending-write status is reported to decode for stall decisions.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/addr/data      writeback requests (valid held until ready)
//   req{0,1}_ready                grant, combinational
//   WE3, A3, WD3                  registered register-file write port
//   q1_addr, q2_addr              decode source addresses to check
//   q1_busy, q2_busy              pending write to that address (combinational)
//   wr_count                      writes issued on WE3 since reset (wraps)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [REG_ADDR_WIDTH-1:0] req0_addr,
    input  logic [REG_DATA_WIDTH-1:0] req0_data,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [REG_ADDR_WIDTH-1:0] req1_addr,
    input  logic [REG_DATA_WIDTH-1:0] req1_data,
    output logic                      req1_ready,
    output logic                      WE3,
    output logic [REG_ADDR_WIDTH-1:0] A3,
    output logic [REG_DATA_WIDTH-1:0] WD3,
    input  logic [REG_ADDR_WIDTH-1:0] q1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] q2_addr,
    output logic                      q1_busy,
    output logic                      q2_busy,
    output logic [CNT_WIDTH-1:0]      wr_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // r_prio names the requester that wins when both are valid.
    logic                      r_prio;
    logic                      r_we;
    logic [REG_ADDR_WIDTH-1:0] r_a3;
    logic [REG_DATA_WIDTH-1:0] r_wd3;
    logic [CNT_WIDTH-1:0]      r_cnt;

    logic                      w_gnt0;
    logic                      w_gnt1;
    logic [REG_ADDR_WIDTH-1:0] w_sel_addr;
    logic [REG_DATA_WIDTH-1:0] w_sel_data;

    // A pending write to q covers the in-flight port write and every
    // outstanding request; x0 is never a hazard.
    function automatic logic addr_busy(
        input logic [REG_ADDR_WIDTH-1:0] q,
        input logic                      we,
        input logic [REG_ADDR_WIDTH-1:0] a3,
        input logic                      v0,
        input logic [REG_ADDR_WIDTH-1:0] a0,
        input logic                      v1,
        input logic [REG_ADDR_WIDTH-1:0] a1
    );
        return (q != '0) && ((we && (a3 == q)) || (v0 && (a0 == q)) || (v1 && (a1 == q)));
    endfunction

    // Grant depends only on valids, the pointer and rst, so there is no
    // path from the output register back to ready.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || !r_prio)) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_sel_addr = w_gnt1 ? req1_addr : req0_addr;
    assign w_sel_data = w_gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
            r_we   <= 1'b0;
            r_a3   <= '0;
            r_wd3  <= '0;
            r_cnt  <= '0;
        end else if (w_gnt0 || w_gnt1) begin
            // Winner loses priority next time; an x0 target is accepted
            // but never reaches the port or the counter.
            r_prio <= w_gnt0;
            r_we   <= (w_sel_addr != '0);
            r_a3   <= w_sel_addr;
            r_wd3  <= w_sel_data;
            if (w_sel_addr != '0) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end else begin
            r_we <= 1'b0;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign WE3        = r_we;
    assign A3         = r_a3;
    assign WD3        = r_wd3;
    assign wr_count   = r_cnt;

    assign q1_busy = addr_busy(q1_addr, r_we, r_a3, req0_valid, req0_addr, req1_valid, req1_addr);
    assign q2_busy = addr_busy(q2_addr, r_we, r_a3, req0_valid, req0_addr, req1_valid, req1_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1;
    logic [AW-1:0] a0, a1, q1, q2;
    logic [DW-1:0] d0, d1;
    logic          r0, r1, we, qb1, qb2;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .REG_ADDR_WIDTH(AW),
        .REG_DATA_WIDTH(DW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(v0),
        .req0_addr (a0),
        .req0_data (d0),
        .req0_ready(r0),
        .req1_valid(v1),
        .req1_addr (a1),
        .req1_data (d1),
        .req1_ready(r1),
        .WE3       (we),
        .A3        (a3),
        .WD3       (wd3),
        .q1_addr   (q1),
        .q2_addr   (q2),
        .q1_busy   (qb1),
        .q2_busy   (qb2),
        .wr_count  (cnt)
    );

    // Reference model: port state after the last edge, fairness pointer,
    // and a plain integer count of real writes.
    int            m_prio;
    bit            m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;
    int            m_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Who should win this cycle: -1 none, else requester index.
    function automatic int grant_of();
        if (rst) return -1;
        if (v0 && v1) return m_prio;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic bit busy_of(input logic [AW-1:0] q);
        if (q == 0) return 1'b0;
        return (m_we && m_a3 == q) || (v0 && a0 == q) || (v1 && a1 == q);
    endfunction

    // One clock: check combinational outputs against current inputs, take
    // the edge, advance the model, check registered outputs.
    task automatic cycle(output int gnt);
        gnt = grant_of();
        #1;
        chk("req0_ready", 32'(r0), 32'(gnt == 0));
        chk("req1_ready", 32'(r1), 32'(gnt == 1));
        chk("q1_busy", 32'(qb1), 32'(busy_of(q1)));
        chk("q2_busy", 32'(qb2), 32'(busy_of(q2)));
        @(posedge clk);
        if (rst) begin
            m_prio = 0; m_we = 0; m_a3 = '0; m_wd = '0; m_cnt = 0;
        end else if (gnt >= 0) begin
            m_prio = 1 - gnt;
            m_a3   = (gnt == 0) ? a0 : a1;
            m_wd   = (gnt == 0) ? d0 : d1;
            m_we   = (m_a3 != 0);
            if (m_we) m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
            m_we = 0;
        end
        #1;
        chk("WE3", 32'(we), 32'(m_we));
        if (m_we) begin
            chk("A3", 32'(a3), 32'(m_a3));
            chk("WD3", wd3, m_wd);
        end
        chk("wr_count", 32'(cnt), 32'(m_cnt));
    endtask

    initial begin
        m_prio = 0; m_we = 0; m_a3 = '0; m_wd = '0; m_cnt = 0;
        rst = 1'b1; v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; q1 = '0; q2 = '0;

        // Reset state
        cycle(g);
        cycle(g);
        chk("rst_A3", 32'(a3), 32'd0);
        chk("rst_WD3", wd3, 32'd0);
        rst = 1'b0;

        // Single write
        v0 = 1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        cycle(g);
        chk("single_A3", 32'(a3), 32'd5);
        chk("single_cnt", 32'(cnt), 32'd1);
        v0 = 0;
        cycle(g);

        // Busy tracking on addr 7, x0 query stays clear
        q1 = 5'd7; q2 = 5'd0;
        v0 = 1; a0 = 5'd7; d0 = 32'h0000_0777;
        cycle(g);
        v0 = 0;
        cycle(g);
        cycle(g);
        chk("busy_after", 32'(qb1), 32'd0);

        // Contention after reset: 0,1,0,1 with addresses 3,4,3,4
        rst = 1; cycle(g); rst = 0;
        v0 = 1; a0 = 5'd3; d0 = 32'h3333_0000;
        v1 = 1; a1 = 5'd4; d1 = 32'h4444_0000;
        q1 = 5'd3; q2 = 5'd4;
        for (int i = 0; i < 4; i++) begin
            cycle(g);
            chk("contend_A3", 32'(a3), (i % 2 == 0) ? 32'd3 : 32'd4);
        end
        v0 = 0; v1 = 0;
        cycle(g);

        // x0 drop from requester 1
        v1 = 1; a1 = 5'd0; d1 = 32'h1234;
        cycle(g);
        chk("x0_we", 32'(we), 32'd0);
        v1 = 0;
        cycle(g);

        // Reset mid-write with both requests held through reset
        v0 = 1; a0 = 5'd9; d0 = 32'h9999_9999;
        cycle(g);
        v1 = 1; a1 = 5'd10; d1 = 32'hAAAA_0000;
        rst = 1;
        cycle(g);
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_cnt", 32'(cnt), 32'd0);
        rst = 0;
        cycle(g);
        chk("midrst_regrant", 32'(g), 32'd0);
        v0 = 0;
        cycle(g);
        v1 = 0;
        cycle(g);

        // Counter wrap: 17 real writes from reset
        rst = 1; cycle(g); rst = 0;
        for (int i = 0; i < 17; i++) begin
            v0 = 1; a0 = AW'(1 + (i % 31)); d0 = $urandom();
            cycle(g);
        end
        v0 = 0;
        cycle(g);
        chk("wrap_cnt", 32'(cnt), 32'd1);

        // Randomized traffic with held-valid discipline
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!v0 && $urandom_range(0, 2) != 0) begin
                v0 = 1; a0 = AW'($urandom_range(0, 7)); d0 = $urandom();
            end
            if (!v1 && $urandom_range(0, 2) != 0) begin
                v1 = 1; a1 = AW'($urandom_range(0, 7)); d1 = $urandom();
            end
            q1 = AW'($urandom_range(0, 7));
            q2 = AW'($urandom_range(0, 7));
            cycle(g);
            if (g == 0) v0 = 0;
            if (g == 1) v1 = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
